// File: rtl/packet_receiver.sv
// Serial packet receiver: hunts for SYNC, decodes the PID, then collects a
// token (addr/endp/crc5) or data payload (data/crc16) and reports the result
// with a one-cycle pkt_valid pulse. Any inValid drop inside a packet aborts it.
//
// Ports
//   clock, rst_n      clock, async active-low reset
//   inBit, inValid    serial bit (MSB first) and its strobe
//   pkt_valid         one-cycle decode-done pulse
//   pkt_type          00 handshake, 01 IN, 10 OUT, 11 data
//   pid, addr, endp, data   decoded fields, held between pulses
//   crc_err, pid_err  status flags, qualified by pkt_valid
//
// state   | meaning
// --------+------------------------------------------------
// S_HUNT  | shifting line bits looking for SYNC
// S_PID   | collecting the 8-bit PID
// S_TOKEN | collecting addr(7) endp(4) crc5(5)
// S_DATA  | collecting data(64) crc16(16)
// S_DONE  | one-cycle result pulse, then back to hunting
module packet_receiver (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        inBit,
   input  logic        inValid,
   output logic        pkt_valid,
   output logic [1:0]  pkt_type,
   output logic [7:0]  pid,
   output logic [6:0]  addr,
   output logic [3:0]  endp,
   output logic [63:0] data,
   output logic        crc_err,
   output logic        pid_err
);

   localparam logic [7:0]  SYNC        = 8'h01;
   localparam logic [7:0]  OUTPID      = 8'h87;
   localparam logic [7:0]  INPID       = 8'h96;
   localparam logic [7:0]  DATAPID     = 8'hC3;
   localparam logic [7:0]  HS_ACK      = 8'h4B;
   localparam logic [7:0]  HS_NAK      = 8'h5A;
   localparam logic [6:0]  TOK_S       = 7'd16;
   localparam logic [6:0]  DATA_S      = 7'd80;
   localparam logic [4:0]  CRC5_POLY   = 5'b00101;
   localparam logic [15:0] CRC16_POLY  = 16'h8005;

   localparam logic [2:0] S_HUNT  = 3'd0;
   localparam logic [2:0] S_PID   = 3'd1;
   localparam logic [2:0] S_TOKEN = 3'd2;
   localparam logic [2:0] S_DATA  = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]  state_q,    state_d;
   // Only 7 bits of sync history are stored: the oldest of the 8 compared
   // bits is shifted out on the same edge, so keeping it would be dead state.
   logic [6:0]  sync_q,     sync_d;
   logic [6:0]  cnt_q,      cnt_d;
   logic        vprev_q,    vprev_d;
   logic [78:0] sr_q,       sr_d;
   logic [4:0]  crc5_q,     crc5_d;
   logic [15:0] crc16_q,    crc16_d;
   logic [1:0]  ptype_q,    ptype_d;
   logic [7:0]  ppid_q,     ppid_d;
   logic        pkt_valid_q, pkt_valid_d;
   logic [1:0]  pkt_type_q, pkt_type_d;
   logic [7:0]  pid_q,      pid_d;
   logic [6:0]  addr_q,     addr_d;
   logic [3:0]  endp_q,     endp_d;
   logic [63:0] data_q,     data_d;
   logic        crc_err_q,  crc_err_d;
   logic        pid_err_q,  pid_err_d;

   logic [79:0] shift_in;
   logic [7:0]  sync_next;
   logic        abort;
   logic        fb5, fb16;

   always_comb begin
      state_d     = state_q;
      sync_d      = sync_q;
      cnt_d       = cnt_q;
      vprev_d     = inValid;
      sr_d        = sr_q;
      crc5_d      = crc5_q;
      crc16_d     = crc16_q;
      ptype_d     = ptype_q;
      ppid_d      = ppid_q;
      pkt_valid_d = 1'b0;
      pkt_type_d  = pkt_type_q;
      pid_d       = pid_q;
      addr_d      = addr_q;
      endp_d      = endp_q;
      data_d      = data_q;
      crc_err_d   = crc_err_q;
      pid_err_d   = pid_err_q;

      shift_in  = {sr_q, inBit};
      sync_next = {sync_q, inBit};
      abort     = !inValid && vprev_q;
      fb5       = inBit ^ crc5_q[4];
      fb16      = inBit ^ crc16_q[15];

      case (state_q)
         S_HUNT: begin
            if (inValid) begin
               sync_d = sync_next[6:0];
               if (sync_next == SYNC) begin
                  state_d = S_PID;
                  cnt_d   = 7'd0;
               end
            end
         end

         S_PID, S_TOKEN, S_DATA: begin
            if (abort) begin
               // Only the status flags change; all fields keep the last packet.
               state_d     = S_DONE;
               cnt_d       = 7'd0;
               pkt_valid_d = 1'b1;
               pid_err_d   = 1'b1;
               crc_err_d   = 1'b0;
            end else if (inValid) begin
               sr_d  = shift_in[78:0];
               cnt_d = cnt_q + 7'd1;
               if (state_q == S_PID) begin
                  if (cnt_q == 7'd7) begin
                     cnt_d   = 7'd0;
                     ppid_d  = shift_in[7:0];
                     crc5_d  = 5'h1F;
                     crc16_d = 16'hFFFF;
                     case (shift_in[7:0])
                        OUTPID: begin
                           state_d = S_TOKEN;
                           ptype_d = 2'b10;
                        end
                        INPID: begin
                           state_d = S_TOKEN;
                           ptype_d = 2'b01;
                        end
                        DATAPID: begin
                           state_d = S_DATA;
                           ptype_d = 2'b11;
                        end
                        HS_ACK, HS_NAK: begin
                           state_d     = S_DONE;
                           pkt_valid_d = 1'b1;
                           pkt_type_d  = 2'b00;
                           pid_d       = shift_in[7:0];
                           crc_err_d   = 1'b0;
                           pid_err_d   = 1'b0;
                        end
                        default: begin
                           state_d     = S_DONE;
                           pkt_valid_d = 1'b1;
                           pid_d       = shift_in[7:0];
                           crc_err_d   = 1'b0;
                           pid_err_d   = 1'b1;
                        end
                     endcase
                  end
               end else if (state_q == S_TOKEN) begin
                  if (cnt_q < 7'd11)
                     crc5_d = {crc5_q[3:0], 1'b0} ^ (fb5 ? CRC5_POLY : 5'b0);
                  if (cnt_q == TOK_S - 7'd1) begin
                     state_d     = S_DONE;
                     cnt_d       = 7'd0;
                     pkt_valid_d = 1'b1;
                     pkt_type_d  = ptype_q;
                     pid_d       = ppid_q;
                     addr_d      = shift_in[15:9];
                     endp_d      = shift_in[8:5];
                     crc_err_d   = (shift_in[4:0] != ~crc5_q);
                     pid_err_d   = 1'b0;
                  end
               end else begin
                  if (cnt_q < 7'd64)
                     crc16_d = {crc16_q[14:0], 1'b0} ^ (fb16 ? CRC16_POLY : 16'h0);
                  if (cnt_q == DATA_S - 7'd1) begin
                     state_d     = S_DONE;
                     cnt_d       = 7'd0;
                     pkt_valid_d = 1'b1;
                     pkt_type_d  = ptype_q;
                     pid_d       = ppid_q;
                     data_d      = shift_in[79:16];
                     crc_err_d   = (shift_in[15:0] != ~crc16_q);
                     pid_err_d   = 1'b0;
                  end
               end
            end
         end

         S_DONE: begin
            state_d = S_HUNT;
            sync_d  = 7'h7F;
            cnt_d   = 7'd0;
         end

         default: begin
            state_d = S_HUNT;
            sync_d  = 7'h7F;
            cnt_d   = 7'd0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_HUNT;
         sync_q      <= 7'h7F;
         cnt_q       <= 7'd0;
         vprev_q     <= 1'b0;
         sr_q        <= '0;
         crc5_q      <= 5'h1F;
         crc16_q     <= 16'hFFFF;
         ptype_q     <= 2'b00;
         ppid_q      <= 8'h00;
         pkt_valid_q <= 1'b0;
         pkt_type_q  <= 2'b00;
         pid_q       <= 8'h00;
         addr_q      <= 7'd0;
         endp_q      <= 4'd0;
         data_q      <= 64'd0;
         crc_err_q   <= 1'b0;
         pid_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sync_q      <= sync_d;
         cnt_q       <= cnt_d;
         vprev_q     <= vprev_d;
         sr_q        <= sr_d;
         crc5_q      <= crc5_d;
         crc16_q     <= crc16_d;
         ptype_q     <= ptype_d;
         ppid_q      <= ppid_d;
         pkt_valid_q <= pkt_valid_d;
         pkt_type_q  <= pkt_type_d;
         pid_q       <= pid_d;
         addr_q      <= addr_d;
         endp_q      <= endp_d;
         data_q      <= data_d;
         crc_err_q   <= crc_err_d;
         pid_err_q   <= pid_err_d;
      end
   end

   assign pkt_valid = pkt_valid_q;
   assign pkt_type  = pkt_type_q;
   assign pid       = pid_q;
   assign addr      = addr_q;
   assign endp      = endp_q;
   assign data      = data_q;
   assign crc_err   = crc_err_q;
   assign pid_err   = pid_err_q;

endmodule

// File: tb/tb_packet_receiver.sv
module tb_packet_receiver;
   logic        clock = 1'b0;
   logic        rst_n, inBit, inValid;
   logic        pkt_valid;
   logic [1:0]  pkt_type;
   logic [7:0]  pid;
   logic [6:0]  addr;
   logic [3:0]  endp;
   logic [63:0] data;
   logic        crc_err, pid_err;

   packet_receiver dut (
      .clock(clock), .rst_n(rst_n), .inBit(inBit), .inValid(inValid),
      .pkt_valid(pkt_valid), .pkt_type(pkt_type), .pid(pid), .addr(addr),
      .endp(endp), .data(data), .crc_err(crc_err), .pid_err(pid_err)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;

   // expected output state
   logic        pend = 1'b0;
   logic [1:0]  e_type;
   logic [7:0]  e_pid;
   logic [6:0]  e_addr;
   logic [3:0]  e_endp;
   logic [63:0] e_data;
   logic        e_crc, e_pe;

   bit frm[$];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      e_type = 2'b00; e_pid = 8'h00; e_addr = 7'd0; e_endp = 4'd0;
      e_data = 64'd0; e_crc = 1'b0; e_pe = 1'b0;
   endtask

   task automatic add(input logic [63:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) frm.push_back(v[i]);
   endtask

   function automatic logic [63:0] fld(input int lo, input int n);
      logic [63:0] v = 64'd0;
      for (int i = 0; i < n; i++) v = {v[62:0], frm[lo + i]};
      return v;
   endfunction

   // Expected CRC field for frm[lo +: n], MSB-first serial CRC of width w.
   function automatic logic [15:0] crc_of(input int lo, input int n, input int w,
                                          input logic [15:0] poly, input logic [15:0] init);
      logic [15:0] mask = 16'hFFFF >> (16 - w);
      logic [15:0] c = init;
      logic        fb;
      for (int i = 0; i < n; i++) begin
         fb = frm[lo + i] ^ c[w - 1];
         c  = ((c << 1) & mask) ^ (fb ? poly : 16'h0);
      end
      return ~c & mask;
   endfunction

   // Decode the current frame from its bit list.
   task automatic model_update(input bit aborted);
      logic [7:0]  sh = 8'hFF;
      logic [63:0] t;
      logic [7:0]  pb;
      int p = 0;
      if (aborted) begin
         e_pe = 1'b1; e_crc = 1'b0;
         return;
      end
      while (p < frm.size()) begin
         sh = {sh[6:0], frm[p]};
         p++;
         if (sh == 8'h01) break;
      end
      t = fld(p, 8); pb = t[7:0];
      if (pb == 8'h87 || pb == 8'h96) begin
         e_type = (pb == 8'h87) ? 2'b10 : 2'b01;
         e_pid  = pb;
         t = fld(p + 8, 7);  e_addr = t[6:0];
         t = fld(p + 15, 4); e_endp = t[3:0];
         t = fld(p + 19, 5);
         e_crc = (t[15:0] != crc_of(p + 8, 11, 5, 16'h0005, 16'h001F));
         e_pe  = 1'b0;
      end else if (pb == 8'hC3) begin
         e_type = 2'b11; e_pid = pb;
         e_data = fld(p + 8, 64);
         t = fld(p + 72, 16);
         e_crc = (t[15:0] != crc_of(p + 8, 64, 16, 16'h8005, 16'hFFFF));
         e_pe  = 1'b0;
      end else if (pb == 8'h4B || pb == 8'h5A) begin
         e_type = 2'b00; e_pid = pb; e_crc = 1'b0; e_pe = 1'b0;
      end else begin
         e_pid = pb; e_crc = 1'b0; e_pe = 1'b1;
      end
   endtask

   // drop < 0: send whole frame; else send 'drop' bits then lower inValid.
   task automatic send(input int drop);
      int n = (drop < 0) ? frm.size() : drop;
      for (int i = 0; i < n; i++) begin
         @(negedge clock);
         inValid = 1'b1; inBit = frm[i];
         if (drop < 0 && i == n - 1) begin
            model_update(1'b0);
            pend = 1'b1;
         end
      end
      if (drop >= 0) begin
         @(negedge clock);
         inValid = 1'b0;
         model_update(1'b1);
         pend = 1'b1;
      end
      repeat (4) begin
         @(negedge clock);
         inValid = 1'b0; inBit = 1'b0;
      end
   endtask

   task automatic build_out_token(input logic [4:0] crc);
      frm.delete();
      add(64'h01, 8); add(64'h87, 8); add(64'b1010000, 7); add(64'b0010, 4); add({59'd0, crc}, 5);
   endtask

   task automatic build_data(input logic [63:0] d);
      logic [15:0] c;
      frm.delete();
      add(64'h01, 8); add(64'hC3, 8); add(d, 64);
      c = crc_of(16, 64, 16, 16'h8005, 16'hFFFF);
      add({48'd0, c}, 16);
   endtask

   // Every-cycle comparison of the DUT against the model.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         chk("cyc_pkt_valid", pkt_valid, pend);
         chk("cyc_pkt_type", pkt_type, e_type);
         chk("cyc_pid", pid, e_pid);
         chk("cyc_addr", addr, e_addr);
         chk("cyc_endp", endp, e_endp);
         chk("cyc_data", data, e_data);
         if (pkt_valid) begin
            chk("cyc_crc_err", crc_err, e_crc);
            chk("cyc_pid_err", pid_err, e_pe);
         end
         pend = 1'b0;
      end
   end

   initial begin
      logic [15:0] c;
      rst_n = 1'b0; inValid = 1'b0; inBit = 1'b0;
      model_reset();
      #2;
      chk("reset_pkt_valid", pkt_valid, 1'b0);
      chk("reset_pid", pid, 8'h00);
      chk("reset_data", data, 64'd0);
      chk("reset_pid_err", pid_err, 1'b0);
      repeat (3) @(negedge clock);
      rst_n = 1'b1;
      repeat (2) @(negedge clock);

      // OUT token, good CRC
      build_out_token(5'b00001);
      send(-1);
      chk("out_model_type", e_type, 2'b10);
      chk("out_model_addr", e_addr, 7'b1010000);
      chk("out_model_crc", e_crc, 1'b0);
      chk("out_dut_pid", pid, 8'h87);
      chk("out_dut_endp", endp, 4'b0010);
      chk("out_dut_crc_err", crc_err, 1'b0);

      // OUT token, last CRC bit flipped
      build_out_token(5'b00000);
      send(-1);
      chk("outbad_model_crc", e_crc, 1'b1);
      chk("outbad_dut_crc_err", crc_err, 1'b1);

      // Handshakes: ACK then NAK, token fields retained
      frm.delete(); add(64'h014B, 16);
      send(-1);
      chk("ack_model_pid", e_pid, 8'h4B);
      chk("ack_dut_type", pkt_type, 2'b00);
      chk("ack_dut_addr_kept", addr, 7'b1010000);
      frm.delete(); add(64'h015A, 16);
      send(-1);
      chk("nak_dut_pid", pid, 8'h5A);
      chk("nak_dut_endp_kept", endp, 4'b0010);

      // IN token with a different address/endpoint
      frm.delete();
      add(64'h01, 8); add(64'h96, 8); add(64'h15, 7); add(64'h9, 4);
      c = crc_of(16, 11, 5, 16'h0005, 16'h001F);
      add({48'd0, c}, 5);
      send(-1);
      chk("in_dut_type", pkt_type, 2'b01);
      chk("in_dut_addr", addr, 7'h15);

      // Data packet, good CRC then one data bit flipped
      build_data(64'hDEADBEEF01234567);
      send(-1);
      chk("data_dut_data", data, 64'hDEADBEEF01234567);
      chk("data_dut_crc_err", crc_err, 1'b0);
      build_data(64'h0F1E2D3C4B5A6978);
      frm[21] = ~frm[21];
      send(-1);
      chk("databad_model_crc", e_crc, 1'b1);
      chk("databad_dut_crc_err", crc_err, 1'b1);

      // Unknown PID
      frm.delete(); add(64'h01FF, 16);
      send(-1);
      chk("badpid_dut_pid_err", pid_err, 1'b1);
      chk("badpid_dut_crc_err", crc_err, 1'b0);

      // Abort after 5 token bits; no later pulse (checked every cycle)
      build_out_token(5'b00001);
      send(21);
      chk("abort_dut_pid_err", pid_err, 1'b1);
      chk("abort_dut_pid_kept", pid, 8'hFF);
      repeat (10) @(negedge clock);

      // Reset in the middle of a data packet
      build_data(64'h1122334455667788);
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         inValid = 1'b1; inBit = frm[i];
      end
      @(negedge clock);
      rst_n = 1'b0; inValid = 1'b0;
      model_reset();
      #1;
      chk("midrst_pid", pid, 8'h00);
      chk("midrst_data", data, 64'd0);
      chk("midrst_type", pkt_type, 2'b00);
      chk("midrst_pid_err", pid_err, 1'b0);
      @(negedge clock);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         inValid = 1'b1; inBit = 1'b1;
      end
      @(negedge clock);
      inValid = 1'b0;
      build_out_token(5'b00001);
      send(-1);
      chk("postrst_dut_addr", addr, 7'b1010000);
      chk("postrst_dut_crc_err", crc_err, 1'b0);
      repeat (3) @(negedge clock);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/packet_receiver.md
PACKET_RECEIVER -- requirements
Module: packet_receiver

Interface
REQ-001 Parameters: none; packet formats, PIDs and sizes are the shared library constants (SYNC, OUTPID, INPID, DATAPID, HS_ACK/HS_NAK PID bytes 8'h4B/8'h5A, TOK_S, HANDSHAKE_S, DATA_S).
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 inBit  input  1  serial line bit, MSB-first, sampled only when inValid=1.
REQ-005 inValid  input  1  bit strobe (the PISO put_outbound); a 1->0 fall mid-packet marks abort.
REQ-006 pkt_valid  output  1  one-cycle pulse, packet decode finished.
REQ-007 pkt_type  output  2  00 handshake, 01 IN token, 10 OUT token, 11 data.
REQ-008 pid  output  8  received PID byte.
REQ-009 addr  output  7  token address field.
REQ-010 endp  output  4  token endpoint field.
REQ-011 data  output  64  data payload, first-received bit at data[63].
REQ-012 crc_err  output  1  CRC mismatch flag, qualified by pkt_valid.
REQ-013 pid_err  output  1  unknown PID or aborted packet, qualified by pkt_valid.

Function
REQ-014 FSM states HUNT, PID, TOKEN, DATA, DONE; bits consumed only in cycles with inValid=1.
REQ-015 HUNT: 8-bit sync shifter (loaded 8'hFF on entry) shifts in each valid bit; when the shifted value equals SYNC (8'b00000001), go to PID.
REQ-016 PID: capture 8 bits into pid; after the 8th bit decode: OUTPID->TOKEN (type 10), INPID->TOKEN (type 01), DATAPID->DATA (type 11), 8'h4B/8'h5A->DONE (type 00), other->DONE with pid_err=1.
REQ-017 TOKEN: 16 bits = addr(7), endp(4), crc5(5); DONE after the 16th bit.
REQ-018 DATA: 80 bits = data(64), crc16(16); DONE after the 80th bit.
REQ-019 Bit counter 7 bits, cleared on every state entry; no wrap within a field.
REQ-020 CRC5: poly 5'b00101, init 5'b11111, over addr then endp in arrival order; per bit fb=bit^crc[4], crc={crc[3:0],0}^(fb?poly:0); expected field = ~crc, MSB first.
REQ-021 CRC16: same scheme, poly 16'h8005, init 16'hFFFF, over the 64 data bits.
REQ-022 crc_err=1 iff received CRC field != expected; always 0 for handshake and pid_err packets.
REQ-023 DONE lasts exactly one cycle: pkt_valid=1 with all outputs valid, then HUNT; pkt_valid latency = 1 cycle after the clock edge sampling the last bit.
REQ-024 pkt_type, pid, addr, endp, data, crc_err, pid_err hold their values between pulses; fields not carried by the current packet type retain previous values.
REQ-025 Abort: inValid=0 in PID, TOKEN or DATA when the previous cycle had inValid=1 -> DONE with pid_err=1, crc_err=0; pkt_type, pid, addr, endp, data unchanged from the previous packet.
REQ-026 inValid low gaps in HUNT are ignored; gaps inside a packet always abort per REQ-025.
REQ-027 Bits arriving during DONE are ignored; the sync shifter restarts from 8'hFF.

Reset
REQ-028 rst_n=0 asynchronously forces HUNT, sync shifter 8'hFF, counter 0, pkt_valid 0, pkt_type 00, pid 8'h00, addr 0, endp 0, data 0, crc_err 0, pid_err 0.
REQ-029 Reset mid-packet discards the partial packet; no pkt_valid until a new SYNC is seen after rst_n rises.

Verification
REQ-030 OUT token 00000001 10000111 1010000 0010 00001 (32 valid bits) -> one pulse, type 10, pid 8'h87, addr 7'b1010000, endp 4'b0010, crc_err 0, pid_err 0, 1 cycle after the last bit.
REQ-031 Same token with last CRC bit flipped (00000) -> pulse, crc_err 1, fields as REQ-030.
REQ-032 HS_ACK frame 16'h014B -> pulse, type 00, pid 8'h4B; then 16'h015A -> pulse, pid 8'h5A; addr and endp retained.
REQ-033 Data packet with valid CRC16 -> type 11, data matches the 64 sent bits, crc_err 0; same packet with any single data bit flipped -> crc_err 1.
REQ-034 SYNC + PID 8'hFF -> pulse with pid_err 1; SYNC + OUTPID, then inValid drops after 5 token bits -> pulse with pid_err 1 and no further pulse.
REQ-035 rst_n pulsed low midway through DATA -> outputs at reset values immediately; the following valid token decodes correctly.
